// File: rtl/ff_descrambler_if.sv
// Stream bundle between the serial link, the descrambler and the frame consumer.
// The slave modport is the descrambler's view; the master modport is the link/consumer side.
interface ff_descrambler_if #(
  parameter int LEN        = 7,
  parameter int FRAME_BITS = 64
);
  localparam int CW = $clog2(FRAME_BITS);

  logic           seed_load;
  logic [LEN-1:0] seed_val;
  logic           in_valid;
  logic           in_bit;
  logic           in_ready;
  logic           out_valid;
  logic           out_bit;
  logic           out_last;
  logic           out_ready;
  logic [CW-1:0]  bit_count;
  logic           frame_done;

  modport master (
    output seed_load, seed_val, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_bit, out_last, bit_count, frame_done
  );

  modport slave (
    input  seed_load, seed_val, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_bit, out_last, bit_count, frame_done
  );
endinterface

// File: rtl/ff_descrambler.sv
// Bit-serial descrambler: recovers x[n] = y[n] ^ XOR(x[n-k]) from a history of recovered bits,
// with valid/ready flow control, per-frame reseeding and frame-boundary marking.
module ff_descrambler #(
  parameter int             LEN        = 7,
  parameter logic [LEN-1:0] TAPS       = 7'b1000001,
  parameter logic [LEN-1:0] SEED       = '0,
  parameter int             FRAME_BITS = 64
) (
  input logic              clk,
  input logic              rst_n,
  ff_descrambler_if.slave  bus
);
  localparam int            CW       = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [LEN-1:0] hist_q, hist_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           out_valid_q, out_valid_d;
  logic           out_bit_q, out_bit_d;
  logic           out_last_q, out_last_d;
  logic           active_q;
  logic           fb, rec, in_ready, acc, consume, frame_done;

  // active_q keeps in_ready low while reset is asserted and for the first cycle after release.
  assign fb       = ^(hist_q & TAPS);
  assign rec      = bus.in_bit ^ fb;
  assign in_ready = active_q & (state_q != DRAIN) & ~bus.seed_load & (~out_valid_q | bus.out_ready);
  assign acc      = bus.in_valid & in_ready;
  assign consume  = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hist_q      <= SEED;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
      active_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    out_last_d  = out_last_q;
    frame_done  = 1'b0;

    if (bus.seed_load) begin
      // Reseed aborts the frame and drops any beat the consumer has not taken yet.
      hist_d      = bus.seed_val;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      state_d     = IDLE;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (acc) begin
            out_bit_d   = rec;
            out_valid_d = 1'b1;
            hist_d      = {hist_q[LEN-2:0], rec};
            state_d     = RUN;
            if (cnt_q == LAST_IDX) begin
              out_last_d = 1'b1;
              cnt_d      = '0;
              state_d    = DRAIN;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else if (consume) begin
            out_valid_d = 1'b0;
          end
        end
        DRAIN: begin
          if (consume) begin
            frame_done  = 1'b1;
            hist_d      = SEED;
            out_last_d  = 1'b0;
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_bit    = out_bit_q;
  assign bus.out_last   = out_last_q;
  assign bus.bit_count  = cnt_q;
  assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_ff_descrambler.sv
// Directed bench for ff_descrambler: a small LEN=2 instance plus the default 64-bit-frame instance
// fed by a bench-side feed-forward scrambler.
module tb_ff_descrambler;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ff_descrambler_if #(.LEN(7), .FRAME_BITS(64)) bus1 ();
  ff_descrambler_if #(.LEN(2), .FRAME_BITS(64)) bus2 ();

  ff_descrambler #(.LEN(7), .TAPS(7'b1000001), .SEED(7'h00), .FRAME_BITS(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  ff_descrambler #(.LEN(2), .TAPS(2'b01), .SEED(2'b00), .FRAME_BITS(64)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );

  int nChecks = 0;
  int nFail   = 0;

  logic       sRdy, sVal, sBit, sLast, sDone;
  logic [5:0] sCnt;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the main instance on the falling edge, then sample its outputs 1 time unit later.
  task automatic applyStimulus(input logic v, input logic b, input logic ordy,
                               input logic sl, input logic [6:0] sv);
    @(negedge clk);
    bus1.in_valid  = v;
    bus1.in_bit    = b;
    bus1.out_ready = ordy;
    bus1.seed_load = sl;
    bus1.seed_val  = sv;
    #1;
    sRdy  = bus1.in_ready;
    sVal  = bus1.out_valid;
    sBit  = bus1.out_bit;
    sLast = bus1.out_last;
    sDone = bus1.frame_done;
    sCnt  = bus1.bit_count;
  endtask

  // Transmit-side scrambler: y = x ^ x[n-1] ^ x[n-7]; h[0] is the newest plain bit.
  function automatic logic scrBit(input logic [6:0] h, input logic x);
    return x ^ h[0] ^ h[6];
  endfunction

  task automatic runFrame(input string tag, input logic [63:0] xw, input logic [6:0] seedS,
                          input int stallAt, input int stallLen);
    logic [6:0]  hs;
    logic [63:0] rx;
    logic        xb, ordy, held, haveHeld;
    int sent, got, cyc, rdyLow, posErr, cntErr, stallErr, extraAcc;
    hs = seedS; rx = '0; held = 1'b0; haveHeld = 1'b0;
    sent = 0; got = 0; cyc = 0; rdyLow = 0; posErr = 0; cntErr = 0; stallErr = 0; extraAcc = 0;
    while (got < 64 && cyc < 400) begin
      ordy = !(cyc >= stallAt && cyc < stallAt + stallLen);
      xb   = (sent < 64) ? xw[63-sent] : 1'b0;
      applyStimulus(1'b1, scrBit(hs, xb), ordy, 1'b0, 7'h00);
      if (!sRdy) rdyLow++;
      if (!ordy) begin
        if (!sVal) stallErr++;
        else if (!haveHeld) begin held = sBit; haveHeld = 1'b1; end
        else if (sBit !== held) stallErr++;
        if (sRdy) stallErr++;
      end
      if (sVal && ordy) begin
        rx[63-got] = sBit;
        if (sLast !== (got == 63)) posErr++;
        if (sDone !== (got == 63)) posErr++;
        if (sCnt !== ((got == 63) ? 6'd0 : 6'(got + 1))) cntErr++;
        got++;
      end else if (sDone !== 1'b0) begin
        posErr++;
      end
      if (sRdy) begin
        if (sent < 64) begin hs = {hs[5:0], xb}; sent++; end
        else extraAcc++;
      end
      cyc++;
    end
    checkOutput({tag, "_beats"}, 64'(got), 64'd64);
    checkOutput({tag, "_data"}, rx, xw);
    checkOutput({tag, "_last_done_pos"}, 64'(posErr), 64'd0);
    checkOutput({tag, "_bit_count"}, 64'(cntErr), 64'd0);
    checkOutput({tag, "_ready_low_cycles"}, 64'(rdyLow), 64'(1 + stallLen));
    checkOutput({tag, "_extra_accept"}, 64'(extraAcc), 64'd0);
    if (stallLen > 0) checkOutput({tag, "_stall_hold"}, 64'(stallErr), 64'd0);
  endtask

  logic [6:0]  y1, x1, hs5;
  logic [63:0] x5;
  logic        xb5;

  initial begin
    rst_n = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_bit = 1'b0; bus1.out_ready = 1'b1;
    bus1.seed_load = 1'b0; bus1.seed_val = '0;
    bus2.in_valid = 1'b0; bus2.in_bit = 1'b0; bus2.out_ready = 1'b1;
    bus2.seed_load = 1'b0; bus2.seed_val = '0;

    // Reset state
    #12;
    checkOutput("rst_out_valid", bus1.out_valid, 1'b0);
    checkOutput("rst_out_bit", bus1.out_bit, 1'b0);
    checkOutput("rst_out_last", bus1.out_last, 1'b0);
    checkOutput("rst_bit_count", bus1.bit_count, 6'd0);
    checkOutput("rst_frame_done", bus1.frame_done, 1'b0);
    checkOutput("rst_in_ready", bus1.in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
    checkOutput("idle_in_ready", sRdy, 1'b1);

    // Case 1: LEN=2, taps x[n-1], y=1,0,1,1,0,1,1 -> x=1,1,0,1,1,0,1
    y1 = 7'b1011011;
    x1 = 7'b1101101;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i == 0) checkOutput("t1_valid_before", bus2.out_valid, 1'b0);
      else begin
        checkOutput($sformatf("t1_valid_%0d", i - 1), bus2.out_valid, 1'b1);
        checkOutput($sformatf("t1_bit_%0d", i - 1), bus2.out_bit, x1[7-i]);
      end
      if (i < 7) begin
        bus2.in_valid = 1'b1;
        bus2.in_bit   = y1[6-i];
      end else begin
        bus2.in_valid = 1'b0;
      end
      #1;
      if (i < 7) checkOutput($sformatf("t1_ready_%0d", i), bus2.in_ready, 1'b1);
    end
    checkOutput("t1_bit_count", bus2.bit_count, 6'd7);

    // Case 2: full frame from SEED, then history back at SEED
    runFrame("t2", 64'hA5C3_0F1E_7788_1234, 7'h00, -1, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
    checkOutput("t2_idle_valid", sVal, 1'b0);
    checkOutput("t2_hist_seed", u_dut.hist_q, 7'h00);

    // Case 3: 5-cycle output stall mid-frame
    runFrame("t3", 64'h1357_9BDF_2468_ACE0, 7'h00, 20, 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h00);

    // Case 4: reseed mid-frame with in_valid high, then decode against 7'h55
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, i[0], 1'b1, 1'b0, 7'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 7'h55);
    checkOutput("t4_ready_on_load", sRdy, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
    checkOutput("t4_valid_after_load", sVal, 1'b0);
    checkOutput("t4_count_after_load", sCnt, 6'd0);
    runFrame("t4", 64'h0123_4567_89AB_CDEF, 7'h55, -1, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h00);

    // Case 5: asynchronous reset at bit 30
    x5  = 64'hFEDC_BA98_7654_3210;
    hs5 = 7'h00;
    for (int i = 0; i < 31; i++) begin
      xb5 = x5[63-i];
      applyStimulus(1'b1, scrBit(hs5, xb5), 1'b1, 1'b0, 7'h00);
      if (sRdy) hs5 = {hs5[5:0], xb5};
    end
    checkOutput("t5_pre_valid", bus1.out_valid, 1'b1);
    checkOutput("t5_pre_count", bus1.bit_count, 6'd30);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_valid", bus1.out_valid, 1'b0);
    checkOutput("t5_rst_bit", bus1.out_bit, 1'b0);
    checkOutput("t5_rst_last", bus1.out_last, 1'b0);
    checkOutput("t5_rst_count", bus1.bit_count, 6'd0);
    checkOutput("t5_rst_done", bus1.frame_done, 1'b0);
    checkOutput("t5_rst_ready", bus1.in_ready, 1'b0);
    bus1.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
    runFrame("t5", x5, 7'h00, -1, 0);

    // Case 6: two frames back to back with in_valid held high
    runFrame("t6a", 64'hDEAD_BEEF_CAFE_F00D, 7'h00, -1, 0);
    runFrame("t6b", 64'h5555_AAAA_3333_CCCC, 7'h00, -1, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
    checkOutput("t6_end_valid", sVal, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
